alu_mc: RTL and testbench

- Parametrised multi-cycle successor of the datapath ALU.
- Keeps the single-cycle ops (AND, ORR, ADD, SUB, PASS-B) and adds logical shifts, iterative unsigned multiply and divide, and full NZCV flags.
- Registered valid/ready handshake on both sides, so the execute stage can stall on long ops.
- Sits between the register-file read stage and the writeback/flags logic.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_basic.sv | 50 +++++
 rtl/alu_mc.sv | 192 +++++++++++++++++++
 tb/tb_alu_mc.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode helpers for the
// multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_LSR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;
    localparam logic [3:0] ALU_UDIV  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_t;

    // Only MUL and UDIV iterate; every other code, known or not, is 1-cycle.
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_UDIV);
    endfunction

endpackage

// File: rtl/alu_basic.sv
// Combinational single-cycle ALU operations with NZCV flag generation.
// Multi-cycle and unknown opcodes produce a zero result here.
module alu_basic
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [3:0]   i_op,
    output logic [N-1:0] o_result,
    output logic         o_zero,
    output logic         o_negative,
    output logic         o_carry,
    output logic         o_overflow
);
    localparam int SW = $clog2(N);

    logic         w_isSub;
    logic [N-1:0] w_opB;
    logic [N:0]   w_sum;

    // SUB reuses the adder as a + ~b + 1 so carry reads as NOT borrow.
    assign w_isSub = (i_op == ALU_SUB);
    assign w_opB   = w_isSub ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_opB} + {{N{1'b0}}, w_isSub};

    always_comb begin
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_op)
            ALU_AND:   o_result = i_a & i_b;
            ALU_ORR:   o_result = i_a | i_b;
            ALU_ADD, ALU_SUB: begin
                o_result   = w_sum[N-1:0];
                o_carry    = w_sum[N];
                o_overflow = (i_a[N-1] == w_opB[N-1]) && (w_sum[N-1] != i_a[N-1]);
            end
            ALU_PASSB: o_result = i_b;
            ALU_LSL:   o_result = i_a << i_b[SW-1:0];
            ALU_LSR:   o_result = i_a >> i_b[SW-1:0];
            default:   o_result = '0;
        endcase
    end

    assign o_zero     = (o_result == '0);
    assign o_negative = o_result[N-1];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle ops via alu_basic, iterative
// shift-add multiply and restoring divide, valid/ready on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow
);
    localparam int CW = $clog2(N) + 1;

    alu_state_t   r_state;
    alu_state_t   w_nextState;

    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_mcand;
    logic [N-1:0]  r_mplier;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_div;

    logic [N-1:0]  r_result;
    logic          r_zero;
    logic          r_negative;
    logic          r_carry;
    logic          r_overflow;

    logic [N-1:0]  w_basicResult;
    logic          w_basicZero;
    logic          w_basicNegative;
    logic          w_basicCarry;
    logic          w_basicOverflow;

    logic          w_accept;
    logic          w_lastStep;
    logic          w_loadFinal;
    logic [N-1:0]  w_accNext;
    logic [N:0]    w_remShift;
    logic          w_remGe;
    logic [N-1:0]  w_remDiff;
    logic [N-1:0]  w_remNext;
    logic [N-1:0]  w_quotNext;
    logic [N-1:0]  w_final;

    alu_basic #(.N(N)) u_basic (
        .i_a        (a),
        .i_b        (b),
        .i_op       (ALUControl),
        .o_result   (w_basicResult),
        .o_zero     (w_basicZero),
        .o_negative (w_basicNegative),
        .o_carry    (w_basicCarry),
        .o_overflow (w_basicOverflow)
    );

    assign w_accept    = in_valid && (r_state == IDLE);
    assign w_lastStep  = (r_cnt == CW'(1));
    assign w_loadFinal = ((r_state == MUL) || (r_state == DIV)) && w_lastStep;

    assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Shifted partial remainder needs N+1 bits; its top bit alone guarantees it fits the divisor.
    assign w_remShift = {r_rem, r_quot[N-1]};
    assign w_remGe    = w_remShift[N] || (w_remShift[N-1:0] >= r_div);
    assign w_remDiff  = w_remShift[N-1:0] - r_div;
    assign w_remNext  = w_remGe ? w_remDiff : w_remShift[N-1:0];
    assign w_quotNext = {r_quot[N-2:0], w_remGe};

    assign w_final = (r_state == MUL) ? w_accNext :
                     ((r_div == '0) ? '0 : w_quotNext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!is_multicycle(ALUControl)) begin
                        w_nextState = DONE;
                    end else if (ALUControl == ALU_MUL) begin
                        w_nextState = MUL;
                    end else begin
                        w_nextState = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (w_lastStep) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_div      <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (ALUControl == ALU_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_cnt    <= CW'(N);
                        end else if (ALUControl == ALU_UDIV) begin
                            r_rem  <= '0;
                            r_quot <= a;
                            r_div  <= b;
                            r_cnt  <= CW'(N);
                        end else begin
                            r_result   <= w_basicResult;
                            r_zero     <= w_basicZero;
                            r_negative <= w_basicNegative;
                            r_carry    <= w_basicCarry;
                            r_overflow <= w_basicOverflow;
                        end
                    end
                end
                MUL: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                end
                DIV: begin
                    r_rem  <= w_remNext;
                    r_quot <= w_quotNext;
                    r_cnt  <= r_cnt - CW'(1);
                end
                default: begin
                end
            endcase

            if (w_loadFinal) begin
                r_result   <= w_final;
                r_zero     <= (w_final == '0);
                r_negative <= w_final[N-1];
                r_carry    <= 1'b0;
                r_overflow <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign carry     = r_carry;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results are queued at accept time
// and compared, with latency, when the DUT presents them.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int N  = 64;
    localparam int SW = $clog2(N);

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ALUControl;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;

    typedef struct {
        logic [N-1:0] result;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
        int           lat;
        int           hold;
        int           acc;
    } expect_t;

    expect_t sb[$];
    expect_t cur;

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;

    bit shown       = 1'b0;
    bit expectDrop  = 1'b0;
    bit randomReady = 1'b0;
    int holdLeft    = 0;

    alu_mc #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .negative   (negative),
        .carry      (carry),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                               input logic [N-1:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cycle);
        end
    endtask

    function automatic expect_t modelAlu(input logic [3:0] op, input logic [N-1:0] x,
                                         input logic [N-1:0] y);
        expect_t    e;
        logic [N:0] s;
        e.result = '0;
        e.c      = 1'b0;
        e.v      = 1'b0;
        e.lat    = 1;
        e.hold   = 0;
        e.acc    = 0;
        case (op)
            4'b0000: e.result = x & y;
            4'b0001: e.result = x | y;
            4'b0010: begin
                s        = {1'b0, x} + {1'b0, y};
                e.result = s[N-1:0];
                e.c      = s[N];
                e.v      = (x[N-1] == y[N-1]) && (e.result[N-1] != x[N-1]);
            end
            4'b0110: begin
                e.result = x - y;
                e.c      = (x >= y);
                e.v      = (x[N-1] != y[N-1]) && (e.result[N-1] != x[N-1]);
            end
            4'b0111: e.result = y;
            4'b0011: e.result = x << y[SW-1:0];
            4'b0100: e.result = x >> y[SW-1:0];
            4'b1000: begin
                e.result = x * y;
                e.lat    = N + 1;
            end
            4'b1001: begin
                e.result = (y == '0) ? '0 : (x / y);
                e.lat    = N + 1;
            end
            default: e.result = '0;
        endcase
        e.z = (e.result == '0);
        e.n = e.result[N-1];
        return e;
    endfunction

    // Output side: compare on first sight, check stability while held, drive out_ready.
    always @(negedge clk) begin
        if (reset) begin
            if (expectDrop) begin
                checkOutput("validDrop", N'(out_valid), N'(0));
                expectDrop = 1'b0;
            end else if (out_valid) begin
                if (!shown) begin
                    checkOutput("sbNonEmpty", N'(sb.size() != 0), N'(1));
                    if (sb.size() != 0) begin
                        cur = sb.pop_front();
                        checkOutput("result", result, cur.result);
                        checkOutput("flagZ", N'(zero), N'(cur.z));
                        checkOutput("flagN", N'(negative), N'(cur.n));
                        checkOutput("flagC", N'(carry), N'(cur.c));
                        checkOutput("flagV", N'(overflow), N'(cur.v));
                        checkOutput("latency", N'(cycle - cur.acc + 1), N'(cur.lat));
                        holdLeft = cur.hold;
                        shown    = 1'b1;
                    end
                end else begin
                    checkOutput("resultStable", result, cur.result);
                end
                checkOutput("inReadyBusy", N'(in_ready), N'(0));
            end
            if (out_valid && shown && holdLeft > 0) begin
                out_ready = 1'b0;
                holdLeft--;
            end else if (randomReady) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = out_valid;
            end
            if (out_valid && shown && out_ready) begin
                shown      = 1'b0;
                expectDrop = 1'b1;
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge following accept.
    task automatic applyStimulus(input logic [3:0] op, input logic [N-1:0] opA,
                                 input logic [N-1:0] opB, input int hold);
        expect_t e;
        in_valid   = 1'b1;
        ALUControl = op;
        a          = opA;
        b          = opB;
        for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
        checkOutput("acceptReady", N'(in_ready), N'(1));
        e      = modelAlu(op, opA, opB);
        e.acc  = cycle + 1;
        e.hold = hold;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drainAll();
        in_valid = 1'b0;
        for (int i = 0; i < 3000 && (sb.size() != 0 || out_valid || expectDrop); i++)
            @(negedge clk);
        checkOutput("drainEmpty", N'(sb.size()), N'(0));
    endtask

    logic [3:0] opList [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011,
                                4'b0100, 4'b1000, 4'b1001, 4'b0101, 4'b1010, 4'b1111};

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        ALUControl = '0;
        out_ready  = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rstInReady", N'(in_ready), N'(1));
        checkOutput("rstOutValid", N'(out_valid), N'(0));
        checkOutput("rstResult", result, '0);
        checkOutput("rstZ", N'(zero), N'(0));
        checkOutput("rstN", N'(negative), N'(0));
        checkOutput("rstC", N'(carry), N'(0));
        checkOutput("rstV", N'(overflow), N'(0));
        @(negedge clk);

        applyStimulus(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        applyStimulus(ALU_SUB, 64'h1234, 64'h1234, 0);
        applyStimulus(ALU_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5);
        applyStimulus(ALU_UDIV, 64'd100, 64'd7, 0);
        applyStimulus(ALU_UDIV, 64'd100, 64'd0, 1);
        applyStimulus(ALU_LSL, 64'd1, 64'h43, 0);
        applyStimulus(ALU_LSR, 64'h8000_0000_0000_0000, 64'h7F, 0);
        applyStimulus(4'b1111, 64'hDEAD_BEEF, 64'h1, 0);
        applyStimulus(ALU_AND, 64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_FFFF_0F0F, 0);
        applyStimulus(ALU_ORR, 64'h8000_0000_0000_0000, 64'h1, 0);
        applyStimulus(ALU_PASSB, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        applyStimulus(ALU_SUB, 64'd1, 64'd2, 0);
        applyStimulus(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 0);
        drainAll();

        // Reset in the middle of a divide discards it immediately.
        applyStimulus(ALU_UDIV, 64'd12345, 64'd3, 0);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("midRstOutValid", N'(out_valid), N'(0));
        checkOutput("midRstInReady", N'(in_ready), N'(1));
        checkOutput("midRstResult", result, '0);
        sb.delete();
        shown      = 1'b0;
        expectDrop = 1'b0;
        holdLeft   = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(ALU_ADD, 64'd40, 64'd2, 0);
        drainAll();

        // Random back-to-back traffic; in_valid stays high while the DUT is busy.
        randomReady = 1'b1;
        for (int k = 0; k < 150; k++) begin
            logic [3:0]   op;
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            op = opList[$urandom_range(0, 11)];
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = N'($urandom_range(0, 20));
                1:       rb = N'($urandom);
                default: rb = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 3) == 0) ra = N'($urandom_range(0, 1000));
            applyStimulus(op, ra, rb, $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drainAll();
        randomReady = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
